// File: rtl/portao_pkg.sv
// portao_pkg: shared definitions for the gate plant emulator.
//   estado_t      : plant state encoding, also driven on the estado debug port
//   SEG_0..SEG_F  : active-low 7-segment patterns {g,f,e,d,c,b,a}
//   SENTIDO_*     : direction command values
package portao_pkg;

  typedef enum logic [2:0] {
    FECHADO  = 3'd0,
    ABRINDO  = 3'd1,
    FECHANDO = 3'd2,
    PARCIAL  = 3'd3,
    ABERTO   = 3'd4
  } estado_t;

  localparam logic SENTIDO_ABRIR  = 1'b1;
  localparam logic SENTIDO_FECHAR = 1'b0;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/portao_planta_hex7seg.sv
// hex7seg: combinational 4-bit to active-low 7-segment decoder.
//   valor    in  4  hex digit
//   segmentos out 7 active-low segments {g,f,e,d,c,b,a}
module hex7seg
  import portao_pkg::*;
(
  input  logic [3:0] valor,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_0;
    case (valor)
      4'h0: segmentos = SEG_0;
      4'h1: segmentos = SEG_1;
      4'h2: segmentos = SEG_2;
      4'h3: segmentos = SEG_3;
      4'h4: segmentos = SEG_4;
      4'h5: segmentos = SEG_5;
      4'h6: segmentos = SEG_6;
      4'h7: segmentos = SEG_7;
      4'h8: segmentos = SEG_8;
      4'h9: segmentos = SEG_9;
      4'hA: segmentos = SEG_A;
      4'hB: segmentos = SEG_B;
      4'hC: segmentos = SEG_C;
      4'hD: segmentos = SEG_D;
      4'hE: segmentos = SEG_E;
      default: segmentos = SEG_F;
    endcase
  end

endmodule

// File: rtl/portao_planta.sv
// portao_planta: gate plant emulator. Turns the controller's motor/sentido
// commands into gate travel (position counter stepped every PASSO_DIV
// motor-on cycles) and reports the limit switches back.
// Ports:
//   clock, reset_n      : clock (rising edge), synchronous active-low reset
//   motor, sentido      : motor on, direction (1 open / 0 close)
//   aberto, fechado     : limit switches, decoded from posicao
//   movendo             : one-cycle pulse on each position step
//   sobrecarga          : motor driving into an active limit
//   posicao, display    : position and its active-low hex digit
//   estado              : debug view of the plant state
// Optional (macro OBSTACULO_EN): obstaculo in, bloqueado out; an obstacle
// freezes closing travel while present.
// Handshake: none; commands are level-sensitive and sampled every rising edge.
module portao_planta
  import portao_pkg::*;
#(
  parameter int CURSO     = 15,
  parameter int PASSO_DIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       motor,
  input  logic       sentido,
`ifdef OBSTACULO_EN
  input  logic       obstaculo,
  output logic       bloqueado,
`endif
  output logic       aberto,
  output logic       fechado,
  output logic       movendo,
  output logic       sobrecarga,
  output logic [3:0] posicao,
  output logic [6:0] display,
  output logic [2:0] estado
);

  localparam int            PW         = (PASSO_DIV > 1) ? $clog2(PASSO_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(PASSO_DIV - 1);
  localparam logic [3:0]    CURSO_L    = 4'(CURSO);

  estado_t       est_q, est_n;
  logic [PW-1:0] presc_q, presc_n, base;
  logic [3:0]    pos_n;
  logic          sentido_q;
  logic          abrir, fechar, stall, inibe, anda, passo;

  always_comb begin
    abrir   = motor && (sentido == SENTIDO_ABRIR);
    fechar  = motor && (sentido == SENTIDO_FECHAR);
    stall   = (abrir && posicao == CURSO_L) || (fechar && posicao == 4'd0);
`ifdef OBSTACULO_EN
    inibe   = obstaculo && fechar && (posicao != 4'd0);
`else
    inibe   = 1'b0;
`endif
    anda    = motor && !stall && !inibe;
    // A reversal discards the partial count, so the new direction waits a
    // full PASSO_DIV cycles; the reversal cycle itself is the first of them.
    base    = (sentido != sentido_q) ? '0 : presc_q;
    presc_n = '0;
    pos_n   = posicao;
    passo   = 1'b0;
    if (anda) begin
      if (base == PRESC_MAX) begin
        passo = 1'b1;
        pos_n = abrir ? posicao + 4'd1 : posicao - 4'd1;
      end else begin
        presc_n = base + PW'(1);
      end
    end
    est_n = PARCIAL;
    if (!motor) begin
      if (pos_n == 4'd0)         est_n = FECHADO;
      else if (pos_n == CURSO_L) est_n = ABERTO;
      else                       est_n = PARCIAL;
    end else if (abrir) begin
      est_n = (pos_n == CURSO_L) ? ABERTO : ABRINDO;
    end else begin
      est_n = (pos_n == 4'd0) ? FECHADO : FECHANDO;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      posicao    <= 4'd0;
      presc_q    <= '0;
      est_q      <= FECHADO;
      movendo    <= 1'b0;
      sobrecarga <= 1'b0;
    end else begin
      posicao    <= pos_n;
      presc_q    <= presc_n;
      est_q      <= est_n;
      movendo    <= passo;
      sobrecarga <= stall;
    end
  end

  // Direction history only; its value right after reset is irrelevant
  // because the counter is already zero.
  always_ff @(posedge clock) begin
    sentido_q <= sentido;
  end

`ifdef OBSTACULO_EN
  always_ff @(posedge clock) begin
    if (!reset_n) bloqueado <= 1'b0;
    else          bloqueado <= inibe;
  end
`endif

  assign aberto  = (posicao == CURSO_L);
  assign fechado = (posicao == 4'd0);
  assign estado  = est_q;

  hex7seg u_hex7seg (
    .valor     (posicao),
    .segmentos (display)
  );

endmodule

// File: tb/tb_portao_planta.sv
module tb_portao_planta;
  import portao_pkg::*;

  localparam int CURSO     = 15;
  localparam int PASSO_DIV = 4;
  localparam int W         = 19;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n, motor, sentido;
  logic aberto, fechado, movendo, sobrecarga;
  logic [3:0] posicao;
  logic [6:0] display;
  logic [2:0] estado;
  logic bloq_obs;
`ifdef OBSTACULO_EN
  logic obstaculo, bloqueado;
  assign bloq_obs = bloqueado;
`else
  assign bloq_obs = 1'b0;
`endif

  always #5 clock = ~clock;

  portao_planta #(.CURSO(CURSO), .PASSO_DIV(PASSO_DIV)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .motor      (motor),
    .sentido    (sentido),
`ifdef OBSTACULO_EN
    .obstaculo  (obstaculo),
    .bloqueado  (bloqueado),
`endif
    .aberto     (aberto),
    .fechado    (fechado),
    .movendo    (movendo),
    .sobrecarga (sobrecarga),
    .posicao    (posicao),
    .display    (display),
    .estado     (estado)
  );

  // reference model: gate position plus length of the current motion run
  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int   m_pos = 0;
  int   m_run = 0;
  logic m_prev_s = 1'b1;
  logic m_mov, m_sob, m_blq;
  estado_t m_est;
  logic obst_m = 1'b0;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelo_passo();
    logic stall, blq, moving, step;
    if (!reset_n) begin
      m_pos = 0; m_run = 0; m_mov = 0; m_sob = 0; m_blq = 0;
      m_est = FECHADO;
    end else begin
      stall  = motor && ((sentido && m_pos == CURSO) || (!sentido && m_pos == 0));
      blq    = obst_m && motor && !sentido && m_pos > 0;
      moving = motor && !stall && !blq;
      if (!moving)                m_run = 0;
      else if (sentido != m_prev_s) m_run = 1;
      else                        m_run = m_run + 1;
      step = moving && (m_run % PASSO_DIV == 0);
      if (step) m_pos = sentido ? m_pos + 1 : m_pos - 1;
      m_mov = step; m_sob = stall; m_blq = blq;
      if (!motor)
        m_est = (m_pos == 0) ? FECHADO : (m_pos == CURSO) ? ABERTO : PARCIAL;
      else if (sentido)
        m_est = (m_pos == CURSO) ? ABERTO : ABRINDO;
      else
        m_est = (m_pos == 0) ? FECHADO : FECHANDO;
    end
    m_prev_s = sentido;
    exp_q.push_back({m_est, hex_tab[m_pos[3:0]], (m_pos == CURSO), (m_pos == 0),
                     m_mov, m_sob, m_blq, m_pos[3:0]});
  endtask

  task automatic confere();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_vazio", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("saidas", {estado, display, aberto, fechado, movendo, sobrecarga, bloq_obs, posicao}, e);
      chk("limite_pos", (posicao <= 4'(CURSO)), 1'b1);
    end
  endtask

  // driver tasks
  task automatic ciclo(input logic m, input logic s, input logic o);
    motor = m; sentido = s;
`ifdef OBSTACULO_EN
    obstaculo = o; obst_m = o;
`else
    obst_m = 1'b0;
    if (o) obst_m = 1'b0;
`endif
    @(posedge clock);
    modelo_passo();
    #1 confere();
  endtask

  task automatic pulso_reset(input logic m);
    reset_n = 1'b0;
    ciclo(m, 1'b1, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    int   len;
    logic rm, rs, ro;
    reset_n = 1'b0; motor = 1'b0; sentido = 1'b1;
`ifdef OBSTACULO_EN
    obstaculo = 1'b0;
`endif
    #2;
    pulso_reset(1'b0);
    pulso_reset(1'b0);
    chk("reset_pos", posicao, 4'd0);
    chk("reset_fechado", fechado, 1'b1);
    chk("reset_aberto", aberto, 1'b0);
    chk("reset_display", display, 7'b1000000);
    chk("reset_estado", estado, FECHADO);

    // full opening
    for (int e = 1; e <= 61; e++) begin
      ciclo(1'b1, 1'b1, 1'b0);
      if (e == 3)  chk("abre_e3_movendo", movendo, 1'b0);
      if (e == 4)  chk("abre_e4_pos", posicao, 4'd1);
      if (e == 4)  chk("abre_e4_movendo", movendo, 1'b1);
      if (e == 59) chk("abre_e59_aberto", aberto, 1'b0);
      if (e == 60) chk("abre_e60_aberto", aberto, 1'b1);
      if (e == 60) chk("abre_e60_pos", posicao, 4'd15);
      if (e == 60) chk("abre_e60_sobrecarga", sobrecarga, 1'b0);
      if (e == 61) chk("abre_e61_sobrecarga", sobrecarga, 1'b1);
      if (e == 61) chk("abre_e61_display", display, 7'b0001110);
    end

    // full closing from open
    for (int e = 1; e <= 61; e++) begin
      ciclo(1'b1, 1'b0, 1'b0);
      if (e == 1)  chk("fecha_e1_sobrecarga", sobrecarga, 1'b0);
      if (e == 3)  chk("fecha_e3_aberto", aberto, 1'b1);
      if (e == 4)  chk("fecha_e4_aberto", aberto, 1'b0);
      if (e == 4)  chk("fecha_e4_pos", posicao, 4'd14);
      if (e == 60) chk("fecha_e60_fechado", fechado, 1'b1);
      if (e == 61) chk("fecha_e61_sobrecarga", sobrecarga, 1'b1);
    end

    // pause mid-travel at 7
    for (int e = 1; e <= 28; e++) ciclo(1'b1, 1'b1, 1'b0);
    chk("pausa_pos_ini", posicao, 4'd7);
    for (int e = 1; e <= 10; e++) begin
      ciclo(1'b0, 1'b1, 1'b0);
      chk("pausa_estado", estado, PARCIAL);
      chk("pausa_pos", posicao, 4'd7);
      chk("pausa_movendo", movendo, 1'b0);
    end
    for (int e = 1; e <= 4; e++) begin
      ciclo(1'b1, 1'b1, 1'b0);
      if (e == 3) chk("retoma_e3_pos", posicao, 4'd7);
      if (e == 4) chk("retoma_e4_pos", posicao, 4'd8);
    end

    // reversal at 5 after two counts
    pulso_reset(1'b0);
    for (int e = 1; e <= 22; e++) ciclo(1'b1, 1'b1, 1'b0);
    chk("reverte_pos_ini", posicao, 4'd5);
    for (int e = 1; e <= 4; e++) begin
      ciclo(1'b1, 1'b0, 1'b0);
      if (e == 2) chk("reverte_e2_pos", posicao, 4'd5);
      if (e == 3) chk("reverte_e3_pos", posicao, 4'd5);
      if (e == 4) chk("reverte_e4_pos", posicao, 4'd4);
    end

    // reset while moving at 9
    pulso_reset(1'b0);
    for (int e = 1; e <= 37; e++) ciclo(1'b1, 1'b1, 1'b0);
    chk("reset_mov_pos_ini", posicao, 4'd9);
    pulso_reset(1'b1);
    chk("reset_mov_pos", posicao, 4'd0);
    chk("reset_mov_fechado", fechado, 1'b1);
    chk("reset_mov_sobrecarga", sobrecarga, 1'b0);
    chk("reset_mov_display", display, 7'b1000000);

`ifdef OBSTACULO_EN
    // obstacle while closing from 10
    for (int e = 1; e <= 40; e++) ciclo(1'b1, 1'b1, 1'b0);
    chk("obst_pos_ini", posicao, 4'd10);
    for (int e = 1; e <= 20; e++) begin
      ciclo(1'b1, 1'b0, 1'b1);
      chk("obst_pos", posicao, 4'd10);
      chk("obst_bloqueado", bloqueado, 1'b1);
    end
    for (int e = 1; e <= 4; e++) begin
      ciclo(1'b1, 1'b0, 1'b0);
      if (e == 1) chk("obst_libera_bloqueado", bloqueado, 1'b0);
      if (e == 3) chk("obst_libera_e3_pos", posicao, 4'd10);
      if (e == 4) chk("obst_libera_e4_pos", posicao, 4'd9);
    end
`endif

    // randomized command segments against the model
    for (int k = 0; k < 300; k++) begin
      len = $urandom_range(1, 12);
      rm  = ($urandom_range(0, 3) != 0);
      rs  = $urandom_range(0, 1);
      ro  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) pulso_reset(rm);
      for (int j = 0; j < len; j++) ciclo(rm, rs, ro);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
